// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-port (A/B) arbiter sharing a single-port RAM with 1-cycle read latency.
// One command latched per grant; all outputs registered.
module ram_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int FIXED_PRI = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;

    state_t              state;
    logic                last_grant;
    logic                owner;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                pick_b;

    // last_grant/owner: 1 = port B
    always_comb pick_b = b_req && (!a_req || (FIXED_PRI == 0 && !last_grant));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: if (a_req || b_req) begin
                    owner      <= pick_b;
                    last_grant <= pick_b;
                    cmd_we     <= pick_b ? b_we : a_we;
                    cmd_addr   <= pick_b ? b_addr : a_addr;
                    cmd_wdata  <= pick_b ? b_wdata : a_wdata;
                    busy       <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    ram_en   <= 1'b1;
                    ram_we   <= cmd_we;
                    ram_addr <= cmd_addr;
                    ram_din  <= cmd_wdata;
                    state    <= cmd_we ? DONE : RDWAIT;
                end
                RDWAIT: begin
                    ram_en <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    a_ack  <= !owner;
                    b_ack  <= owner;
                    if (!cmd_we)
                        rdata <= ram_dout;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
